// File: rtl/riscv_core_pred_recovery_queue.sv
// Branch recovery unit: in-order prediction queue, resolve-time check, redirect/flush/training.
// Optional performance counters are compiled in with `define RISCV_PRED_PERF_CNT_EN.
module riscv_core_pred_recovery_queue #(
  parameter int ALEN         = 64,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pred_push,
  input  logic [ALEN-1:0]  i_pred_pc,
  input  logic             i_pred_hit,
  input  logic             i_pred_taken,
  input  logic [ALEN-1:0]  i_pred_target,
  input  logic [ALEN-1:0]  i_pred_pc_next,
  output logic             o_pred_full,
  output logic             o_pred_empty,
  input  logic             i_res_valid,
  input  logic             i_res_branch,
  input  logic             i_res_jump,
  input  logic             i_res_taken,
  input  logic [ALEN-1:0]  i_res_target,
  output logic             o_mis_prediction,
  output logic [ALEN-1:0]  o_recovery_address,
  output logic             o_flush,
  output logic             o_upd_valid,
  output logic [ALEN-1:0]  o_upd_pc,
  output logic             o_upd_taken,
  output logic [ALEN-1:0]  o_upd_target,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt,
  output logic             o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Handshake: a push is taken when i_pred_push=1 and o_pred_full=0, or when the
  // queue is full but the head is popped in the same cycle; a resolve pops the
  // head when i_res_valid=1 and the queue is non-empty. Both are ignored in FLUSH.

  state_t          state;
  logic [FW-1:0]   flush_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [ALEN-1:0] q_pc      [DEPTH];
  logic [ALEN-1:0] q_target  [DEPTH];
  logic [ALEN-1:0] q_pc_next [DEPTH];
  logic            q_hit     [DEPTH];
  logic            q_taken   [DEPTH];

  logic            ptr_empty;
  logic            ptr_full;
  logic            in_run;
  logic            do_pop;
  logic            do_push;
  logic            do_check;
  logic            do_mis;
  logic            ovf_det;
  logic            unf_det;
  logic            is_mis;
  logic [ALEN-1:0] rec_addr;

  logic [ALEN-1:0] h_pc;
  logic [ALEN-1:0] h_target;
  logic [ALEN-1:0] h_pc_next;
  logic            h_hit;
  logic            h_taken;

  assign ptr_empty = (wr_ptr == rd_ptr);
  assign ptr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_run       = (state == ST_RUN);
  assign o_pred_empty = ptr_empty;
  assign o_pred_full  = ptr_full || (state == ST_FLUSH);
  assign o_dbg_state  = (state == ST_FLUSH);

  assign h_pc      = q_pc[rd_ptr[AW-1:0]];
  assign h_target  = q_target[rd_ptr[AW-1:0]];
  assign h_pc_next = q_pc_next[rd_ptr[AW-1:0]];
  assign h_hit     = q_hit[rd_ptr[AW-1:0]];
  assign h_taken   = q_taken[rd_ptr[AW-1:0]];

  assign do_pop   = in_run && i_res_valid && !ptr_empty;
  assign do_push  = in_run && i_pred_push && (!ptr_full || do_pop);
  assign do_check = do_pop && (i_res_branch || i_res_jump);
  assign do_mis   = do_check && is_mis;
  assign ovf_det  = in_run && i_pred_push && ptr_full && !do_pop;
  assign unf_det  = in_run && i_res_valid && ptr_empty;

  // Jump wins when both type bits are set; only a predicted-taken branch that
  // falls through recovers to the stored fall-through PC.
  always_comb begin
    is_mis   = 1'b0;
    rec_addr = i_res_target;
    if (i_res_jump) begin
      is_mis = !(h_hit && h_taken && (i_res_target == h_target));
    end else if (!h_hit || !h_taken) begin
      is_mis = i_res_taken;
    end else if (!i_res_taken) begin
      is_mis   = 1'b1;
      rec_addr = h_pc_next;
    end else begin
      is_mis = (i_res_target != h_target);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      q_pc[wr_ptr[AW-1:0]]      <= i_pred_pc;
      q_target[wr_ptr[AW-1:0]]  <= i_pred_target;
      q_pc_next[wr_ptr[AW-1:0]] <= i_pred_pc_next;
      q_hit[wr_ptr[AW-1:0]]     <= i_pred_hit;
      q_taken[wr_ptr[AW-1:0]]   <= i_pred_taken;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= ST_RUN;
      flush_cnt          <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      o_flush            <= 1'b0;
      o_mis_prediction   <= 1'b0;
      o_recovery_address <= '0;
      o_upd_valid        <= 1'b0;
      o_upd_pc           <= '0;
      o_upd_taken        <= 1'b0;
      o_upd_target       <= '0;
      o_overflow         <= 1'b0;
      o_underflow        <= 1'b0;
    end else begin
      o_mis_prediction <= do_mis;
      o_upd_valid      <= do_check;
      o_overflow       <= ovf_det;
      o_underflow      <= unf_det;
      if (do_check) begin
        o_upd_pc     <= h_pc;
        o_upd_taken  <= i_res_jump | i_res_taken;
        o_upd_target <= i_res_target;
      end
      if (do_mis) begin
        o_recovery_address <= rec_addr;
      end
      case (state)
        ST_RUN: begin
          if (do_mis) begin
            // Purge drops every queued record, including a same-cycle push.
            state     <= ST_FLUSH;
            flush_cnt <= FW'(FLUSH_CYCLES);
            o_flush   <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
          end else begin
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt <= FW'(1)) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            o_flush   <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        default: begin
          state   <= ST_RUN;
          o_flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef RISCV_PRED_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (do_check && (branch_cnt != '1))  branch_cnt  <= branch_cnt + CNT_W'(1);
      if (do_mis && (mispred_cnt != '1))   mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

  assign o_branch_cnt  = branch_cnt;
  assign o_mispred_cnt = mispred_cnt;
`else
  assign o_branch_cnt  = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule

// File: doc/riscv_core_pred_recovery_queue.md
Name: riscv_core_pred_recovery_queue

Overview:
Next-generation branch recovery unit. Fetch pushes one prediction record per fetched instruction into an in-order queue. Execute resolves instructions in order; the unit compares each resolved branch or jump against its queued prediction. On mismatch it issues a registered redirect, a multi-cycle pipeline flush, a queue purge and predictor-training updates. It sits between the fetch-stage predictor/BTB and the execute-stage branch unit.

Parameters:
ALEN, 64, address width
DEPTH, 4, queue entries (power of 2, >=2)
FLUSH_CYCLES, 2, cycles o_flush is held (>=1)
CNT_W, 32, performance counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_pred_push  in  1  fetch pushes a record
i_pred_pc  in  ALEN  PC of fetched instruction
i_pred_hit  in  1  BTB hit (prediction valid)
i_pred_taken  in  1  predicted taken
i_pred_target  in  ALEN  predicted target
i_pred_pc_next  in  ALEN  pc+4 or pc+2 fall-through
o_pred_full  out  1  queue cannot accept a push
o_pred_empty  out  1  queue empty
i_res_valid  in  1  execute resolves the head instruction
i_res_branch  in  1  head is a conditional branch
i_res_jump  in  1  head is a jump
i_res_taken  in  1  branch-unit outcome
i_res_target  in  ALEN  computed target
o_mis_prediction  out  1  redirect pulse
o_recovery_address  out  ALEN  redirect PC
o_flush  out  1  flush younger pipeline stages
o_upd_valid  out  1  predictor-training pulse
o_upd_pc  out  ALEN  training PC
o_upd_taken  out  1  training outcome
o_upd_target  out  ALEN  training target
o_overflow  out  1  push dropped (1-cycle pulse)
o_underflow  out  1  resolve on empty queue (1-cycle pulse)
o_branch_cnt  out  CNT_W  resolved branches and jumps
o_mispred_cnt  out  CNT_W  mispredictions

Behaviour:
- Reset: all outputs 0; queue empty (o_pred_empty=1); FSM in RUN; counters 0.
- Queue: circular buffer with log2(DEPTH)+1-bit read/write pointers; wrap-around by pointer MSB.
  - Full: pointers differ only in MSB. Empty: pointers equal.
  - o_pred_full and o_pred_empty are combinational from the pointers, except o_pred_full is forced to 1 in FLUSH.
- Push when full and no simultaneous pop: dropped, o_overflow pulses next cycle.
  - Push and pop together when full: both are performed.
- Resolve on empty queue: ignored, o_underflow pulses next cycle. No bypass of a same-cycle push.
- Resolve with i_res_branch=i_res_jump=0: pops the head, no check, no update.
- Check for the head entry (E) when branch=1:
  - E.hit=0: mispredict iff taken; recovery = res_target.
  - E.hit=1, pred_taken=0, taken=1: mispredict, recovery = res_target.
  - E.hit=1, pred_taken=1, taken=0: mispredict, recovery = E.pc_next.
  - E.hit=1, both taken: mispredict iff res_target != E.target; recovery = res_target.
- Check when jump=1: mispredict unless E.hit and E.pred_taken and res_target == E.target; recovery = res_target.
- branch=jump=1: treated as jump.
- Latency: resolve in cycle N gives these outputs in N+1.
  - o_upd_valid=1 for every checked branch/jump, with o_upd_pc=E.pc, o_upd_taken = taken (jump: 1), o_upd_target=res_target.
  - On mispredict: o_mis_prediction=1 for exactly one cycle; o_recovery_address holds its value until the next mispredict.
- FSM RUN -> FLUSH on mispredict detect at cycle N.
  - The queue is purged at the N edge, discarding any same-cycle push.
  - o_flush is high cycles N+1..N+FLUSH_CYCLES, driven by a down-counter.
  - In FLUSH, pushes and resolves are ignored: no overflow/underflow pulses, no updates.
  - FLUSH -> RUN when the counter reaches 0; pushes are accepted from the following cycle.
- Async reset mid-FLUSH: returns to RUN, empty queue, o_flush=0 immediately.

Optional Feature:
RISCV_PRED_PERF_CNT_EN
- Defined: o_branch_cnt increments on every checked branch/jump; o_mispred_cnt increments on every mispredict. Both saturate at all-ones.
- Undefined: no counter registers; both ports are tied to 0.

Test Plan:
- Push pc=0x100, hit=1, taken=1, target=0x200; resolve branch taken, target 0x200 -> no mispredict; o_upd_valid=1, o_upd_pc=0x100, next cycle.
- Push hit=1, taken=1, pc_next=0x104; resolve branch not-taken -> o_mis_prediction pulse with recovery 0x104; o_flush high for 2 cycles; o_pred_empty=1; same-cycle push discarded.
- Push hit=1, taken=1, target=0x300; resolve jump target 0x340 -> mispredict, recovery 0x340. Repeat with hit=0 -> mispredict, recovery 0x340.
- Fill 4 entries, push a 5th -> o_overflow pulse, o_pred_full=1. Then push+resolve in the same cycle -> occupancy stays 4, pointers wrap correctly over 10 iterations.
- Resolve on empty queue -> o_underflow pulse, no update. Assert i_rst_n low in the 2nd FLUSH cycle -> o_flush=0 and queue empty immediately.
- With RISCV_PRED_PERF_CNT_EN: 5 branches with 2 mispredicts -> o_branch_cnt=5, o_mispred_cnt=2. Without the macro: both read 0.
